// File: rtl/int_sched.sv
// ---------------------------------------------------------------------------
// int_sched -- three-line priority interrupt scheduler with nesting support.
//
// Raw interrupt levels are turned into pending requests on their rising edge.
// The highest-priority pending line that outranks everything currently in
// service is offered to the pipeline. When the pipeline accepts it, the
// return PC is pushed onto a small EPC stack and the line moves into service.
// A handler return (eret) retires the most recent in-service line and pops
// its return PC.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   irq_in     raw interrupt levels, a 0->1 transition is a request
//   ei / di    one-cycle pulses: enable / disable interrupts
//   int_ack    pipeline accepts the offered interrupt this cycle
//   epc_in     return PC captured on int_ack
//   eret       one-cycle pulse: handler return
//   int_req    interrupt entry requested of the pipeline
//   int_vec    entry address of the granted line (0 when idle)
//   epc_out    top of the EPC stack, 0 when empty
//   ir         pending-request register
//   irs        in-service register
//   ie         global interrupt enable
//   bad_eret   one-cycle pulse after an eret arriving with nothing in service
// ---------------------------------------------------------------------------
module int_sched #(
  parameter logic [31:0] VEC0 = 32'h0000_3000,
  parameter logic [31:0] VEC1 = 32'h0000_3100,
  parameter logic [31:0] VEC2 = 32'h0000_3200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        ei,
  input  logic        di,
  input  logic        int_ack,
  input  logic [31:0] epc_in,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] int_vec,
  output logic [31:0] epc_out,
  output logic [2:0]  ir,
  output logic [2:0]  irs,
  output logic        ie,
  output logic        bad_eret
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  grant;
  logic [2:0]  irq_prev;
  logic [2:0]  rise;
  logic [2:0]  elig_mask;
  logic [2:0]  eligible;
  logic [2:0]  sel;
  logic [2:0]  irs_top;
  logic        ack_fire;
  logic        eret_ok;
  logic [2:0]  ir_next;
  logic [2:0]  irs_next;
  logic [1:0]  sp;
  logic [31:0] stack [3];

  // Map a one-hot line selection onto its handler entry address.
  function automatic logic [31:0] vec_of(input logic [2:0] onehot);
    logic [31:0] v;
    v = '0;
    if (onehot[2])      v = VEC2;
    else if (onehot[1]) v = VEC1;
    else if (onehot[0]) v = VEC0;
    return v;
  endfunction

  // Priority resolution. A line may only be offered if it outranks the
  // highest line already in service, so a lower or equal priority request
  // waits in ir until the running handler returns.
  always_comb begin
    rise = irq_in & ~irq_prev;

    elig_mask = 3'b111;
    if (irs[2])      elig_mask = 3'b000;
    else if (irs[1]) elig_mask = 3'b100;
    else if (irs[0]) elig_mask = 3'b110;

    eligible = ir & elig_mask;

    sel = 3'b000;
    if (eligible[2])      sel = 3'b100;
    else if (eligible[1]) sel = 3'b010;
    else if (eligible[0]) sel = 3'b001;

    irs_top = 3'b000;
    if (irs[2])      irs_top = 3'b100;
    else if (irs[1]) irs_top = 3'b010;
    else if (irs[0]) irs_top = 3'b001;
  end

  // Handshake qualifiers and next values for the request/service registers.
  // A fresh edge is OR-ed in after the ack clear so that a new request on the
  // line being accepted is not lost. When eret and ack coincide the eret
  // retirement is applied first and the newly accepted line added after.
  always_comb begin
    ack_fire = (state == REQ) && int_ack;
    eret_ok  = eret && (irs != 3'b000);

    ir_next = ir;
    if (ack_fire) ir_next = ir_next & ~grant;
    ir_next = ir_next | rise;

    irs_next = irs;
    if (eret_ok)  irs_next = irs_next & ~irs_top;
    if (ack_fire) irs_next = irs_next | grant;
  end

  // Entry handshake FSM. The grant is latched on entry to REQ and held until
  // the pipeline acks, so a later higher-priority edge cannot swap the vector
  // out from under a pipeline that may already be acting on it. An ack seen
  // while idle has nothing to accept and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 3'b000;
      int_req <= 1'b0;
      int_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ie && (sel != 3'b000)) begin
            state   <= REQ;
            grant   <= sel;
            int_req <= 1'b1;
            int_vec <= vec_of(sel);
          end
        end
        REQ: begin
          if (int_ack) begin
            state   <= IDLE;
            grant   <= 3'b000;
            int_req <= 1'b0;
            int_vec <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= 3'b000;
          int_req <= 1'b0;
          int_vec <= '0;
        end
      endcase
    end
  end

  // Request/service/enable registers. irq_prev tracks irq_in during reset so
  // a level already high at reset release is not mistaken for a new edge.
  // The enable has a fixed precedence: entry clears it, return sets it, then
  // the software di/ei pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= irq_in;
      ir       <= 3'b000;
      irs      <= 3'b000;
      ie       <= 1'b0;
      bad_eret <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      ir       <= ir_next;
      irs      <= irs_next;
      bad_eret <= eret && (irs == 3'b000);
      if (ack_fire)     ie <= 1'b0;
      else if (eret_ok) ie <= 1'b1;
      else if (di)      ie <= 1'b0;
      else if (ei)      ie <= 1'b1;
    end
  end

  // EPC stack. Depth tracks popcount(irs): every accepted line pushes and
  // every valid return pops. A newly granted line always outranks everything
  // in service, so a push only happens with at most two entries live and the
  // stack cannot overflow. A simultaneous pop and push overwrites the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= 2'd0;
      for (int i = 0; i < 3; i++) stack[i] <= '0;
    end else begin
      if (ack_fire && eret_ok) begin
        stack[sp - 2'd1] <= epc_in;
      end else if (ack_fire) begin
        stack[sp] <= epc_in;
        sp        <= sp + 2'd1;
      end else if (eret_ok) begin
        sp <= sp - 2'd1;
      end
    end
  end

  // Top of stack, reading as zero when nothing is in service.
  always_comb begin
    epc_out = '0;
    if (sp != 2'd0) epc_out = stack[sp - 2'd1];
  end

endmodule
